// File: rtl/disp_pkg.sv
// Shared types and defaults for the seven-segment display sharing arbiter.
// The width helper never returns zero, so 1-wide counters stay legal.
package disp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } disp_state_e;

    localparam int         TICK_DIV_DEF   = 200000;
    localparam logic [7:0] IDLE_VALUE_DEF = 8'h00;

    // Bits needed to index n distinct values (ceil(log2(n)), minimum 1).
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// Combinational round-robin picker: searches upward from last_owner+1 with wrap,
// so the previous owner is considered last; the _excl outputs never return it.
module disp_rr_pick
    import disp_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = clog2_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_owner_i,
    output logic             any_o,
    output logic [IW-1:0]    pick_o,
    output logic             any_excl_o,
    output logic [IW-1:0]    pick_excl_o
);

    logic [IW-1:0] idx_c;

    always_comb begin
        any_o       = 1'b0;
        pick_o      = last_owner_i;
        any_excl_o  = 1'b0;
        pick_excl_o = last_owner_i;
        idx_c       = last_owner_i;
        // Walk from the farthest candidate to the nearest; the nearest hit wins.
        for (int i = N_REQ; i >= 1; i--) begin
            idx_c = IW'((int'(last_owner_i) + i) % N_REQ);
            if (req_i[idx_c]) begin
                any_o  = 1'b1;
                pick_o = idx_c;
                if (i != N_REQ) begin
                    any_excl_o  = 1'b1;
                    pick_excl_o = idx_c;
                end
            end
        end
    end

endmodule

// File: rtl/disp_share_arbiter.sv
// Round-robin owner of the shared 4-digit display with a guaranteed minimum
// hold time per owner; the owner's value is forwarded to the display registered.
module disp_share_arbiter
    import disp_pkg::*;
#(
    parameter  int                N_REQ      = 4,
    parameter  int                DATA_W     = 8,
    parameter  int                TICK_DIV   = TICK_DIV_DEF,
    parameter  int                HOLD_TICKS = 250,
    parameter  logic [DATA_W-1:0] IDLE_VALUE = DATA_W'(IDLE_VALUE_DEF),
    localparam int                IW         = clog2_w(N_REQ)
) (
    input  logic                    sclk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [IW-1:0]           owner,
    output logic [DATA_W-1:0]       disp_data,
    output logic                    disp_valid
);

    localparam int            CW        = clog2_w(TICK_DIV);
    localparam int            HW        = clog2_w(HOLD_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
    localparam logic [IW-1:0] OWNER_TOP = IW'(N_REQ - 1);

    disp_state_e       state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_owner_q, last_owner_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [HW-1:0]     hold_q, hold_d;

    logic              tick;
    logic              expired;
    logic              grant_change;
    logic              rr_any, rr_any_excl;
    logic [IW-1:0]     rr_pick, rr_pick_excl;
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    disp_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .any_o        (rr_any),
        .pick_o       (rr_pick),
        .any_excl_o   (rr_any_excl),
        .pick_excl_o  (rr_pick_excl)
    );

    assign tick    = (cnt_q == CNT_LAST);
    assign expired = (hold_q == HOLD_MAX);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        data_d       = data_q;
        valid_d      = valid_q;
        case (state_q)
            IDLE: begin
                // The new owner's value shows up one edge after the grant.
                if (rr_any) begin
                    state_d      = HOLD;
                    grant_d      = N_REQ'(1) << rr_pick;
                    owner_d      = rr_pick;
                    last_owner_d = rr_pick;
                    valid_d      = 1'b1;
                end
            end
            HOLD: begin
                // A released owner keeps the display frozen until its hold runs out.
                if (req[owner_q]) begin
                    data_d = data_arr[owner_q];
                end
                if (expired) begin
                    if (rr_any_excl) begin
                        grant_d      = N_REQ'(1) << rr_pick_excl;
                        owner_d      = rr_pick_excl;
                        last_owner_d = rr_pick_excl;
                    end else if (!req[owner_q]) begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        data_d  = IDLE_VALUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Both timers restart whenever ownership moves, so every owner gets a full hold.
    always_comb begin
        grant_change = (grant_d != grant_q);
        if (grant_change || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        if (grant_change) begin
            hold_d = '0;
        end else if (tick && !expired) begin
            hold_d = hold_q + HW'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= OWNER_TOP;
            data_q       <= IDLE_VALUE;
            valid_q      <= 1'b0;
            cnt_q        <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
        end
    end

    assign grant      = grant_q;
    assign owner      = owner_q;
    assign disp_data  = data_q;
    assign disp_valid = valid_q;

endmodule
